// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: streams limb pairs LSB-first into a registered adder stage
// and gathers the sums. Define MP_ADD_SUB_EN to add the `sub` input (A - B via ~B + 1).
module mp_add_seq #(
   parameter int WIDTH = 8,
   parameter int LIMBS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [WIDTH*LIMBS-1:0]   op_a,
   input  logic [WIDTH*LIMBS-1:0]   op_b,
   input  logic                     cin,
`ifdef MP_ADD_SUB_EN
   input  logic                     sub,
`endif
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   output logic                     add_ci,
   input  logic [WIDTH-1:0]         add_s,
   input  logic                     add_co,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH*LIMBS-1:0]   result,
   output logic                     cout
);
   // state | meaning
   // IDLE  | waiting for start, adder drives held at 0
   // RUN   | limb idx presented to the adder; limb idx-1 sum collected
   // FLUSH | last limb sum and carry collected
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(LIMBS - 1);

   logic [1:0]             state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [WIDTH*LIMBS-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic                   ci_q, ci_d, cout_q, cout_d, done_q, done_d;
   logic                   sub_sel;

`ifdef MP_ADD_SUB_EN
   assign sub_sel = sub;
`else
   assign sub_sel = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      ci_d     = ci_q;
      result_d = result_q;
      cout_d   = cout_q;
      done_d   = 1'b0;
      add_a    = '0;
      add_b    = '0;
      add_ci   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               idx_d   = '0;
               a_d     = op_a;
               // Subtraction is A + ~B + 1; the forced carry-in supplies the +1.
               b_d     = sub_sel ? ~op_b : op_b;
               ci_d    = sub_sel ? 1'b1 : cin;
            end
         end
         ST_RUN: begin
            add_a  = a_q[int'(idx_q)*WIDTH +: WIDTH];
            add_b  = b_q[int'(idx_q)*WIDTH +: WIDTH];
            add_ci = (idx_q == '0) ? ci_q : add_co;
            for (int i = 0; i < LIMBS - 1; i++) begin
               if (int'(idx_q) == i + 1)
                  result_d[i*WIDTH +: WIDTH] = add_s;
            end
            if (idx_q == IDX_LAST)
               state_d = ST_FLUSH;
            else
               idx_d = idx_q + 1'b1;
         end
         ST_FLUSH: begin
            result_d[(LIMBS-1)*WIDTH +: WIDTH] = add_s;
            cout_d  = add_co;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         ci_q     <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ci_q     <= ci_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq with a behavioural registered adder stage attached.
module tb_mp_add_seq;
   localparam int WIDTH = 8;
   localparam int LIMBS = 4;
   localparam int N = WIDTH * LIMBS;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [N-1:0]     op_a = '0, op_b = '0;
   logic             cin = 1'b0;
`ifdef MP_ADD_SUB_EN
   logic             sub = 1'b0;
`endif
   logic [WIDTH-1:0] add_a, add_b, add_s;
   logic             add_ci, add_co;
   logic             busy, done, cout;
   logic [N-1:0]     result;
   int               total = 0;
   int               bad = 0;

   always #5 clk = ~clk;

   // Registered ripple-carry adder stage the sequencer drives.
   always_ff @(posedge clk)
      {add_co, add_s} <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};

   mp_add_seq #(.WIDTH(WIDTH), .LIMBS(LIMBS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef MP_ADD_SUB_EN
      .sub(sub),
`endif
      .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
      .busy(busy), .done(done), .result(result), .cout(cout)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents an operation before edge 0; returns at the negedge after edge 0.
   task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
      @(negedge clk);
      op_a = a; op_b = b; cin = c; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Steps edges from_edge..LIMBS+1, checking done only at the last one.
   task automatic wait_done(input string tag, input int from_edge,
                            input logic [N-1:0] exp_res, input logic exp_co);
      for (int k = from_edge; k <= LIMBS + 1; k++) begin
         @(posedge clk); #1;
         if (k == LIMBS + 1) chk({tag, "_done"}, done, 1'b1);
         else if (done) chk({tag, "_early_done"}, done, 1'b0);
      end
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_cout"}, cout, exp_co);
      @(posedge clk); #1;
      chk({tag, "_done_one_cycle"}, done, 1'b0);
   endtask

   initial begin
      bit seen_done;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, '0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_drives", {add_a, add_b, add_ci}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      launch(32'h000000FF, 32'h00000001, 1'b0);
      chk("t1_busy", busy, 1'b1);
      chk("t1_limb0", {add_a, add_b, add_ci}, {8'hFF, 8'h01, 1'b0});
      wait_done("t1", 1, 32'h00000100, 1'b0);

      launch(32'hFFFFFFFF, 32'h00000001, 1'b0);
      @(posedge clk); #1;
      chk("t2_limb1_carry", {add_a, add_b, add_ci}, {8'hFF, 8'h00, 1'b1});
      wait_done("t2", 2, 32'h00000000, 1'b1);

      // Re-start pulsed mid-run must be ignored.
      launch(32'h12345678, 32'h11111111, 1'b1);
      chk("t3_ci0", add_ci, 1'b1);
      @(posedge clk);
      @(negedge clk);
      op_a = 32'hAAAAAAAA; op_b = 32'h55555555; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 3; k <= LIMBS + 1; k++) begin
         @(posedge clk); #1;
      end
      chk("t3_done", done, 1'b1);
      chk("t3_result", result, 32'h2345678A);
      chk("t3_cout", cout, 1'b0);
      // Back-to-back: start asserted during the done cycle.
      launch(32'h00000001, 32'h00000001, 1'b0);
      chk("t4_b2b_busy", busy, 1'b1);
      wait_done("t4", 1, 32'h00000002, 1'b0);

      // Abort with idx=2.
      launch(32'h0F0F0F0F, 32'h01010101, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_result", result, '0);
      chk("abort_cout", cout, 1'b0);
      chk("abort_drives", {add_a, add_b, add_ci}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      chk("abort_no_done", seen_done, 1'b0);
      launch(32'h00000001, 32'h00000002, 1'b0);
      wait_done("t5", 1, 32'h00000003, 1'b0);

`ifdef MP_ADD_SUB_EN
      @(negedge clk);
      sub = 1'b1;
      launch(32'h00000005, 32'h00000007, 1'b0);
      sub = 1'b0;
      wait_done("sub", 1, 32'hFFFFFFFE, 1'b0);
      @(negedge clk);
      sub = 1'b1;
      launch(32'h00000007, 32'h00000005, 1'b0);
      sub = 1'b0;
      wait_done("sub2", 1, 32'h00000002, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
